// File: rtl/spi_mem_responder.sv
// SPI device-side responder: decodes CMD/ADDR/[DUMMY]/DATA frames from the master and backs them
// with a small word memory. All SPI inputs are synchronous to clk_i; sclk edges are detected locally.
module spi_mem_responder #(
  parameter int unsigned Depth       = 64,
  parameter int unsigned DummyCycles = 34,
  parameter logic [7:0]  CmdWr       = 8'h02,
  parameter logic [7:0]  CmdRd       = 8'h0B,
  localparam int unsigned Aw         = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          spi_sclk,
  input  logic          spi_sdi,
  input  logic          spi_cs,
  output logic          spi_sdo,
  output logic          spi_sdo_oe,
  output logic          wr_valid_o,
  output logic [31:0]   wr_addr_o,
  output logic [31:0]   wr_data_o,
  output logic          rd_valid_o,
  output logic          err_o,
  input  logic [Aw-1:0] dbg_addr_i,
  output logic [31:0]   dbg_rdata_o
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
  } state_e;

  state_e        state_q, state_d;
  logic          sclk_q;
  logic          rise, fall, last;
  logic [7:0]    cnt_q, cnt_d;
  logic [30:0]   shift_q, shift_d;
  logic [31:0]   shift_in;
  logic          addr_oor;
  logic          cmd_rd_q, cmd_rd_d;
  logic [31:0]   addr_q, addr_d;
  logic          oor_q, oor_d;
  logic [31:0]   rd_word_q, rd_word_d;
  logic          wr_valid_q, wr_valid_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic [31:0]   mem_q [Depth];
  logic          mem_we;
  logic [Aw-1:0] mem_idx;

  assign rise     = spi_sclk & ~sclk_q;
  assign fall     = ~spi_sclk & sclk_q;
  assign last     = (cnt_q == '0);
  assign shift_in = {shift_q, spi_sdi};
  assign addr_oor = ((shift_in >> (Aw + 2)) != '0);
  assign mem_idx  = addr_q[Aw+1:2];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; chip-select high overrides everything
  always_comb begin
    state_d = state_q;
    if (spi_cs) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StCmd;
        StCmd: begin
          if (rise && last) begin
            state_d = (shift_in[7:0] == CmdWr || shift_in[7:0] == CmdRd) ? StAddr : StIgnore;
          end
        end
        StAddr:  if (rise && last) state_d = cmd_rd_q ? StDummy : StWdata;
        StDummy: if (rise && last) state_d = StRdata;
        StRdata, StWdata: if (rise && last) state_d = StCmd;
        StIgnore: state_d = StIgnore;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    cmd_rd_d   = cmd_rd_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    rd_word_d  = rd_word_q;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    if (state_d != state_q) begin
      unique case (state_d)
        StCmd:                    cnt_d = 8'd7;
        StAddr, StRdata, StWdata: cnt_d = 8'd31;
        StDummy:                  cnt_d = 8'(DummyCycles - 1);
        default:                  cnt_d = '0;
      endcase
    end else if (rise && !last) begin
      cnt_d = cnt_q - 8'd1;
    end

    if (!spi_cs) begin
      if (rise && (state_q == StCmd || state_q == StAddr || state_q == StWdata)) begin
        shift_d = shift_in[30:0];
      end
      if (rise && last) begin
        unique case (state_q)
          StCmd: begin
            cmd_rd_d = (shift_in[7:0] == CmdRd);
            if (shift_in[7:0] != CmdWr && shift_in[7:0] != CmdRd) err_d = 1'b1;
          end
          StAddr: begin
            addr_d = shift_in;
            oor_d  = addr_oor;
            if (addr_oor) err_d = 1'b1;
          end
          StDummy: begin
            rd_word_d  = oor_q ? '0 : mem_q[mem_idx];
            rd_valid_d = 1'b1;
          end
          StWdata: begin
            if (!oor_q) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = shift_in;
            end
          end
          default: ;
        endcase
      end else if (fall && state_q == StRdata && cnt_q != 8'd31) begin
        // The fall right after entry precedes the first read rise, so bit 31 is held through it
        rd_word_d = {rd_word_q[30:0], 1'b0};
      end
    end

    dbg_rdata_d = (mem_we && mem_idx == dbg_addr_i) ? shift_in : mem_q[dbg_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      cmd_rd_q    <= 1'b0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      rd_word_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dbg_rdata_q <= '0;
    end else begin
      sclk_q      <= spi_sclk;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      cmd_rd_q    <= cmd_rd_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      rd_word_q   <= rd_word_d;
      wr_valid_q  <= wr_valid_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory is deliberately not reset so completed writes survive a mid-frame reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_idx] <= shift_in;
  end

  // Output logic
  always_comb begin
    spi_sdo_oe  = (state_q == StRdata) && !spi_cs;
    spi_sdo     = spi_sdo_oe & rd_word_q[31];
    wr_valid_o  = wr_valid_q;
    rd_valid_o  = rd_valid_q;
    wr_addr_o   = wr_addr_q;
    wr_data_o   = wr_data_q;
    err_o       = err_q;
    dbg_rdata_o = dbg_rdata_q;
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: bit-banged SPI master against a word-array model
// of the memory, sticky error flag and pulse counts.
module tb_spi_mem_responder;

  localparam int unsigned Depth = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_sdi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdo, spi_sdo_oe, wr_valid_o, rd_valid_o, err_o;
  logic [31:0] wr_addr_o, wr_data_o, dbg_rdata_o;
  logic [5:0]  dbg_addr_i = '0;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] model_mem [Depth];
  bit          model_vld [Depth];

  spi_mem_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .spi_sclk    (spi_sclk),
    .spi_sdi     (spi_sdi),
    .spi_cs      (spi_cs),
    .spi_sdo     (spi_sdo),
    .spi_sdo_oe  (spi_sdo_oe),
    .wr_valid_o  (wr_valid_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .rd_valid_o  (rd_valid_o),
    .err_o       (err_o),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_rdata_o (dbg_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (wr_valid_o === 1'b1) wr_cnt++;
    if (rd_valid_o === 1'b1) rd_cnt++;
  end

  // Shift n bits of val (MSB first); rx collects spi_sdo as seen just before each rise
  task automatic spi_xfer(input logic [31:0] val, input int n, output logic [31:0] rx,
                          output int oe_cnt);
    rx = '0;
    oe_cnt = 0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk_i); spi_sdi = val[i];
      @(negedge clk_i);
      rx = {rx[30:0], spi_sdo};
      if (spi_sdo_oe === 1'b1) oe_cnt++;
      spi_sclk = 1'b1;
      @(negedge clk_i); @(negedge clk_i);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic set_cs(input logic v);
    @(negedge clk_i); spi_cs = v;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rx;
    int oe;
    spi_xfer(32'h02, 8, rx, oe);
    spi_xfer(addr, 32, rx, oe);
    spi_xfer(data, 32, rx, oe);
    if (addr < 4 * Depth) begin
      model_mem[addr[7:2]] = data;
      model_vld[addr[7:2]] = 1'b1;
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] rx, output int oe_cnt);
    logic [31:0] dummy;
    int oe;
    spi_xfer(32'h0B, 8, dummy, oe);
    spi_xfer(addr, 32, dummy, oe);
    spi_xfer(32'h0, 32, dummy, oe);
    spi_xfer(32'h0, 2, dummy, oe);
    spi_xfer($urandom, 32, rx, oe_cnt);
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    return (addr < 4 * Depth) ? model_mem[addr[7:2]] : 32'h0;
  endfunction

  task automatic dbg_read(input int idx, output logic [31:0] val);
    @(negedge clk_i); dbg_addr_i = 6'(idx);
    repeat (2) @(negedge clk_i);
    val = dbg_rdata_o;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (spi_sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got=%b exp=0", spi_sdo); end
    total++; if (spi_sdo_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", spi_sdo_oe); end
    total++; if (wr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wrv got=%b exp=0", wr_valid_o); end
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b exp=0", rd_valid_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    total++; if (wr_addr_o !== 32'h0 || wr_data_o !== 32'h0) begin
      bad++; $display("FAIL rst_wr_regs got=%h/%h exp=0/0", wr_addr_o, wr_data_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_write;
    logic [31:0] v;
    int w0 = wr_cnt;
    set_cs(1'b0);
    do_write(32'd100, 32'd100);
    total++; if (wr_cnt - w0 != 1) begin bad++; $display("FAIL t1_pulses got=%0d exp=1", wr_cnt - w0); end
    total++; if (wr_addr_o !== 32'd100) begin bad++; $display("FAIL t1_addr got=%0d exp=100", wr_addr_o); end
    total++; if (wr_data_o !== 32'd100) begin bad++; $display("FAIL t1_data got=%0d exp=100", wr_data_o); end
    dbg_read(25, v);
    total++; if (v !== 32'd100) begin bad++; $display("FAIL t1_dbg got=%h exp=64", v); end
  endtask

  task automatic test_read;
    logic [31:0] rx;
    int oe;
    int r0 = rd_cnt;
    do_read(32'd100, rx, oe);
    total++; if (rx !== 32'h64) begin bad++; $display("FAIL t2_data got=%h exp=00000064", rx); end
    total++; if (oe != 32) begin bad++; $display("FAIL t2_oe got=%0d exp=32", oe); end
    total++; if (rd_cnt - r0 != 1) begin bad++; $display("FAIL t2_rdv got=%0d exp=1", rd_cnt - r0); end
    repeat (2) @(negedge clk_i);
    total++; if (spi_sdo_oe !== 1'b0) begin bad++; $display("FAIL t2_oe_after got=%b exp=0", spi_sdo_oe); end
    set_cs(1'b1);
  endtask

  task automatic test_abort;
    logic [31:0] rx, v, d;
    int oe;
    int w0 = wr_cnt;
    set_cs(1'b0);
    spi_xfer(32'h02, 8, rx, oe);
    spi_xfer(32'd100, 32, rx, oe);
    spi_xfer(32'hFFFF_FFFF, 20, rx, oe);
    set_cs(1'b1);
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL t3_nowrite got=%0d exp=0", wr_cnt - w0); end
    dbg_read(25, v);
    total++; if (v !== 32'd100) begin bad++; $display("FAIL t3_mem got=%h exp=64", v); end
    d = $urandom;
    set_cs(1'b0);
    do_write(32'd4, d);
    set_cs(1'b1);
    dbg_read(1, v);
    total++; if (v !== d) begin bad++; $display("FAIL t3_next got=%h exp=%h", v, d); end
  endtask

  task automatic test_range;
    logic [31:0] rx;
    int oe;
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL t5_err_pre got=%b exp=0", err_o); end
    set_cs(1'b0);
    do_write(32'h1000, 32'hA5A5_A5A5);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL t5_err got=%b exp=1", err_o); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL t5_nowrite got=%0d exp=0", wr_cnt - w0); end
    do_read(32'h1000, rx, oe);
    total++; if (rx !== 32'h0) begin bad++; $display("FAIL t5_rdata got=%h exp=0", rx); end
    total++; if (rd_cnt - r0 != 1) begin bad++; $display("FAIL t5_rdv got=%0d exp=1", rd_cnt - r0); end
    set_cs(1'b1);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rx, v;
    int oe;
    set_cs(1'b0);
    spi_xfer(32'h02, 8, rx, oe);
    spi_xfer(32'h0000_0020, 16, rx, oe);
    @(negedge clk_i); rst_ni = 1'b0;
    #1;
    total++; if (err_o !== 1'b0 || spi_sdo_oe !== 1'b0 || spi_sdo !== 1'b0) begin
      bad++; $display("FAIL t6_rst got=err%b oe%b sdo%b exp=0", err_o, spi_sdo_oe, spi_sdo);
    end
    spi_cs = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    set_cs(1'b0);
    do_write(32'd8, 32'hDEAD_BEEF);
    set_cs(1'b1);
    dbg_read(2, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t6_dbg got=%h exp=deadbeef", v); end
    dbg_read(25, v);
    total++; if (v !== 32'd100) begin bad++; $display("FAIL t6_keep got=%h exp=64", v); end
  endtask

  task automatic test_bad_opcode;
    logic [31:0] rx, v, d;
    int oe, oe2;
    int w0 = wr_cnt;
    set_cs(1'b0);
    spi_xfer(32'h9F, 8, rx, oe);
    repeat (2) @(negedge clk_i);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL t4_err got=%b exp=1", err_o); end
    spi_xfer(32'h02, 32, rx, oe);
    spi_xfer($urandom, 32, rx, oe2);
    total++; if (oe + oe2 != 0) begin bad++; $display("FAIL t4_oe got=%0d exp=0", oe + oe2); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL t4_nowrite got=%0d exp=0", wr_cnt - w0); end
    set_cs(1'b1);
    d = $urandom;
    set_cs(1'b0);
    do_write(32'd12, d);
    set_cs(1'b1);
    total++; if (wr_cnt - w0 != 1 || wr_data_o !== d) begin
      bad++; $display("FAIL t4_recover got=%0d/%h exp=1/%h", wr_cnt - w0, wr_data_o, d);
    end
    dbg_read(3, v);
    total++; if (v !== d) begin bad++; $display("FAIL t4_dbg got=%h exp=%h", v, d); end
  endtask

  // Randomised back-to-back writes and reads inside one chip-select frame
  task automatic test_back_to_back;
    logic [31:0] rx, addr, data, v;
    int oe;
    set_cs(1'b0);
    for (int n = 0; n < 24; n++) begin
      int unsigned idx = $urandom_range(Depth - 1);
      addr = {22'h0, 6'(idx), 2'($urandom_range(3))};
      if (!model_vld[idx] || $urandom_range(1) == 0) begin
        data = $urandom;
        do_write(addr, data);
        total++; if (wr_addr_o !== addr || wr_data_o !== data) begin
          bad++; $display("FAIL b2b_wr got=%h/%h exp=%h/%h", wr_addr_o, wr_data_o, addr, data);
        end
      end else begin
        do_read(addr, rx, oe);
        total++; if (rx !== exp_read(addr) || oe != 32) begin
          bad++; $display("FAIL b2b_rd addr=%h got=%h/%0d exp=%h/32", addr, rx, oe, exp_read(addr));
        end
      end
    end
    set_cs(1'b1);
    for (int i = 0; i < Depth; i++) begin
      if (model_vld[i]) begin
        dbg_read(i, v);
        total++; if (v !== model_mem[i]) begin
          bad++; $display("FAIL b2b_dbg idx=%0d got=%h exp=%h", i, v, model_mem[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) begin
      model_mem[i] = '0;
      model_vld[i] = 1'b0;
    end
    test_reset;
    test_write;
    test_read;
    test_abort;
    test_range;
    test_reset_mid;
    test_bad_opcode;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
